// File: rtl/ssp_fifo_pkg.sv
// ssp_fifo_pkg
// Shared constants and helpers for the parametrised SSP FIFO controllers
// (receive side here, transmit side later).
//   SSP_FIFO_DEPTH_DEFAULT : default number of FIFO entries
//   SSP_FIFO_TO_W_DEFAULT  : default width of the receive timeout counter
//   sspPtrWidth()          : pointer/level width for a given depth, i.e.
//                            address bits plus one wrap bit
package ssp_fifo_pkg;

  localparam int SSP_FIFO_DEPTH_DEFAULT = 8;
  localparam int SSP_FIFO_TO_W_DEFAULT  = 8;

  function automatic int sspPtrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ssp_fifo_timeout.sv
// ssp_fifo_timeout
// Saturating receive-timeout counter and its raw interrupt flop.
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_start        : FIFO activity this cycle, restarts the count from 0
//   i_enable       : FIFO holds data; the count is held at 0 while low
//   i_clear        : flush, zeroes the count and the interrupt
//   i_intClr       : interrupt clear (software clear or a data read)
//   i_limit        : timeout in clock cycles, 0 disables counting
//   o_rtris        : raw timeout interrupt status
module ssp_fifo_timeout
  import ssp_fifo_pkg::*;
#(
  parameter int TO_W = SSP_FIFO_TO_W_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_enable,
  input  logic            i_clear,
  input  logic            i_intClr,
  input  logic [TO_W-1:0] i_limit,
  output logic            o_rtris
);

  logic [TO_W-1:0] r_count;
  logic            r_rtris;
  logic [TO_W-1:0] w_next;
  logic            w_counting;
  logic            w_hit;

  // Counting stops once the limit is reached, so the counter saturates
  // and never wraps, even if the limit is lowered below the current count.
  assign w_next     = r_count + TO_W'(1);
  assign w_counting = i_enable & ~i_start & ~i_clear &
                      (i_limit != '0) & (r_count < i_limit);
  assign w_hit      = w_counting & (w_next == i_limit);

  // The interrupt is set on the same edge the count reaches the limit;
  // any clear source wins over a simultaneous set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_rtris <= 1'b0;
    end else begin
      if (i_clear | i_start | ~i_enable) begin
        r_count <= '0;
      end else if (w_counting) begin
        r_count <= w_next;
      end

      if (i_clear | i_intClr) begin
        r_rtris <= 1'b0;
      end else if (w_hit) begin
        r_rtris <= 1'b1;
      end
    end
  end

  assign o_rtris = r_rtris;

endmodule

// File: rtl/ssp_rx_fifo_cntl_p.sv
// ssp_rx_fifo_cntl_p
// Control block for the SSP receive FIFO: pointers, fill level, status
// flags, watermark, overrun and receive-timeout interrupts, and flush.
// Inputs:
//   i_PCLK, i_PRESET      : APB clock, synchronous active-high reset
//   i_RxFWrSync           : toggle-style write request from the SSPCLK side
//   i_TESTFIFO/i_SSPTDRWr : test-mode direct write path
//   i_RxFRdPtrInc         : APB read of the data register
//   i_RxFlush             : synchronous flush
//   i_RxWm, i_RxTo        : watermark and timeout settings
//   i_RXIM/i_RORIM/i_RTIM : interrupt masks
//   i_RORIC/i_RTIC        : interrupt clears
// Outputs:
//   o_RegFileWrEn, o_WrPtr, o_RdPtr : register-file write strobe and addresses
//   o_RxFLevel, o_RNE, o_RFF        : fill level, not empty, full
//   o_*RIS / o_*MIS                 : raw and masked interrupt status
module ssp_rx_fifo_cntl_p
  import ssp_fifo_pkg::*;
#(
  parameter int DEPTH = SSP_FIFO_DEPTH_DEFAULT,
  parameter int PTR_W = sspPtrWidth(DEPTH) - 1,
  parameter int TO_W  = SSP_FIFO_TO_W_DEFAULT
) (
  input  logic             i_PCLK,
  input  logic             i_PRESET,
  input  logic             i_RxFWrSync,
  input  logic             i_TESTFIFO,
  input  logic             i_SSPTDRWr,
  input  logic             i_RxFRdPtrInc,
  input  logic             i_RxFlush,
  input  logic [PTR_W:0]   i_RxWm,
  input  logic [TO_W-1:0]  i_RxTo,
  input  logic             i_RXIM,
  input  logic             i_RORIM,
  input  logic             i_RTIM,
  input  logic             i_RORIC,
  input  logic             i_RTIC,
  output logic             o_RegFileWrEn,
  output logic [PTR_W-1:0] o_WrPtr,
  output logic [PTR_W-1:0] o_RdPtr,
  output logic [PTR_W:0]   o_RxFLevel,
  output logic             o_RNE,
  output logic             o_RFF,
  output logic             o_RXRIS,
  output logic             o_RORRIS,
  output logic             o_RTRIS,
  output logic             o_RXMIS,
  output logic             o_RORMIS,
  output logic             o_RTMIS
);

  localparam int             LW       = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_LVL = LW'(DEPTH);

  logic [PTR_W:0] r_wptr;
  logic [PTR_W:0] r_rptr;
  logic           r_delRxFWrSync;
  logic           r_rorris;

  logic [PTR_W:0] w_level;
  logic           w_rne;
  logic           w_rff;
  logic           w_wrReq;
  logic           w_rdValid;
  logic           w_wrAcc;
  logic           w_overrun;
  logic [PTR_W:0] w_effWm;
  logic           w_rtris;

  // The extra wrap bit makes full (difference DEPTH) distinct from empty.
  assign w_level = r_wptr - r_rptr;
  assign w_rne   = (w_level != '0);
  assign w_rff   = (w_level == FULL_LVL);

  // Requests are masked during reset so no register-file write can leak
  // out while the pointers are being cleared.
  assign w_wrReq   = ((i_RxFWrSync ^ r_delRxFWrSync) | (i_TESTFIFO & i_SSPTDRWr)) & ~i_PRESET;
  assign w_rdValid = i_RxFRdPtrInc & w_rne & ~i_RxFlush & ~i_PRESET;
  assign w_wrAcc   = w_wrReq & (~w_rff | w_rdValid) & ~i_RxFlush;
  assign w_overrun = w_wrReq & w_rff & ~w_rdValid & ~i_RxFlush;

  // Clamp the watermark into 1..DEPTH.
  always_comb begin
    w_effWm = i_RxWm;
    if (i_RxWm == '0) begin
      w_effWm = LW'(1);
    end else if (i_RxWm > FULL_LVL) begin
      w_effWm = FULL_LVL;
    end
  end

  // Pointer update; the sync delay flop keeps tracking during a flush so
  // that a toggle arriving with the flush is simply dropped.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_delRxFWrSync <= 1'b0;
    end else begin
      r_delRxFWrSync <= i_RxFWrSync;
      if (i_RxFlush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wrAcc) begin
          r_wptr <= r_wptr + LW'(1);
        end
        if (w_rdValid) begin
          r_rptr <= r_rptr + LW'(1);
        end
      end
    end
  end

  // Sticky overrun flag; a new overrun beats a clear in the same cycle.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      r_rorris <= 1'b0;
    end else if (w_overrun) begin
      r_rorris <= 1'b1;
    end else if (i_RORIC) begin
      r_rorris <= 1'b0;
    end
  end

  ssp_fifo_timeout #(
    .TO_W(TO_W)
  ) u_timeout (
    .i_clk   (i_PCLK),
    .i_reset (i_PRESET),
    .i_start (w_wrAcc | w_rdValid),
    .i_enable(w_rne),
    .i_clear (i_RxFlush),
    .i_intClr(i_RTIC | w_rdValid),
    .i_limit (i_RxTo),
    .o_rtris (w_rtris)
  );

  assign o_RegFileWrEn = w_wrAcc;
  assign o_WrPtr       = r_wptr[PTR_W-1:0];
  assign o_RdPtr       = r_rptr[PTR_W-1:0];
  assign o_RxFLevel    = w_level;
  assign o_RNE         = w_rne;
  assign o_RFF         = w_rff;
  assign o_RXRIS       = (w_level >= w_effWm);
  assign o_RORRIS      = r_rorris;
  assign o_RTRIS       = w_rtris;
  assign o_RXMIS       = o_RXRIS & i_RXIM;
  assign o_RORMIS      = r_rorris & i_RORIM;
  assign o_RTMIS       = w_rtris & i_RTIM;

endmodule
